mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result (effective address or computed value), the store data and the decode fields.
- Performs loads and stores over a request/grant/response data-memory interface: byte-lane alignment, store-data replication, load sign/zero extension.
- Presents one writeback packet per accepted instruction, with a valid/ready handshake on both sides.

Parameters:
- DWIDTH, 32, data width; the byte-lane logic is defined for 32 only.
- AWIDTH, 32, address width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset. Asynchronous, active-low.
- ex_valid_i  input  1  execute presents an instruction.
- ex_ready_o  output  1  stage can accept.
- ex_pc_i  input  AWIDTH  instruction PC.
- ex_res_i  input  DWIDTH  ALU result; effective address for load/store.
- ex_rs2_i  input  DWIDTH  store data.
- ex_opcode_i  input  7  opcode.
- ex_funct3_i  input  3  funct3.
- ex_rd_i  input  5  destination register.
- dmem_req_o  output  1  memory request valid.
- dmem_gnt_i  input  1  memory accepted the request.
- dmem_we_o  output  1  1 = store.
- dmem_addr_o  output  AWIDTH  word-aligned address: ex_res_i with bits [1:0] forced to 0.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  DWIDTH  store data, lane-replicated.
- dmem_rvalid_i  input  1  read data valid.
- dmem_rdata_i  input  DWIDTH  read word.
- wb_valid_o  output  1  writeback packet valid.
- wb_ready_i  input  1  writeback consumes the packet.
- wb_we_o  output  1  register write enable.
- wb_rd_o  output  5  destination register.
- wb_data_o  output  DWIDTH  writeback value.
- err_o  output  1  misaligned access or illegal funct3; qualified by wb_valid_o.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- ex_ready_o = (state == IDLE). Handshake occurs when ex_valid_i && ex_ready_o; all inputs are registered at that edge.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0 except ex_ready_o, which goes to 1.
  - An outstanding memory transaction is abandoned; an rvalid arriving after reset is ignored in IDLE.
- Non-memory op, accepted at cycle T: IDLE->RESP; wb_valid_o=1 at T+1.
  - JAL/JALR: wb_data = pc+4.
  - All other ops: wb_data = ex_res_i.
- Load/store with a legal, aligned access: IDLE->REQ.
  - REQ: dmem_req_o=1 and all dmem_* outputs held stable until dmem_gnt_i.
  - On grant, a store goes REQ->RESP; a load goes REQ->WAIT.
  - WAIT: on dmem_rvalid_i, capture and extend the read data, then go to RESP.
  - rvalid is only honoured in WAIT, never in the grant cycle.
- Misaligned or illegal access: IDLE->RESP with err_o=1, wb_we_o=0, no memory request issued.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load 011/110/111; store 011 and above.
- RESP: hold wb_* stable while wb_ready_i=0. When wb_ready_i=1, go RESP->IDLE; the next instruction is accepted no earlier than the following cycle.
- Store byte lanes, with off = addr[1:0]:
  - SB: be = 0001 << off; wdata = rs2[7:0] replicated to 4 lanes.
  - SH: be = 0011 << off; wdata = rs2[15:0] replicated twice.
  - SW: be = 1111; wdata = rs2.
- Load extraction: select lane by off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- wb_we_o = 1 for LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR when rd != 0 and err_o = 0.
  - wb_we_o = 0 for STORE and BRANCH.
- Minimum latency with grant in the REQ cycle and rvalid one cycle later:
  - load accepted at T gives wb_valid_o at T+3;
  - store accepted at T gives wb_valid_o at T+2.

Test Plan:
1. ADD, ex_res_i=0x0000_0042, rd=5, wb_ready_i=1 -> wb_valid_o at T+1, wb_data_o=0x42, wb_we_o=1, ex_ready_o back to 1 at T+2.
2. LB at address 0x1003, memory returns 0x80AB_CDEF -> dmem_addr_o=0x1000, dmem_be_o=1111, wb_data_o=0xFFFF_FF80. Repeat as LBU -> wb_data_o=0x0000_0080.
3. SH at 0x2002, rs2=0x1234_5678, grant held low for 3 cycles -> dmem_req_o/addr/be/wdata stable for 4 cycles with dmem_be_o=1100 and dmem_wdata_o=0x5678_5678; wb_we_o=0 in RESP.
4. LW at 0x3001 -> no dmem_req_o pulse; wb_valid_o at T+1 with err_o=1, wb_we_o=0.
5. JAL with pc=0x100, rd=1, wb_ready_i held low for 2 cycles -> wb_data_o=0x104 held stable; ex_ready_o=0 throughout the stall.
6. Reset asserted in WAIT, then rvalid pulses after reset release -> stage is in IDLE, wb_valid_o stays 0, the next ADD completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Execute, data-memory and writeback signals of the memory-access stage, named from the stage's side.
// The slave modport is the stage; the master modport drives execute, memory and writeback.
interface mem_access_stage_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [AWIDTH-1:0] ex_pc_i;
    logic [DWIDTH-1:0] ex_res_i;
    logic [DWIDTH-1:0] ex_rs2_i;
    logic [6:0]        ex_opcode_i;
    logic [2:0]        ex_funct3_i;
    logic [4:0]        ex_rd_i;

    logic              dmem_req_o;
    logic              dmem_gnt_i;
    logic              dmem_we_o;
    logic [AWIDTH-1:0] dmem_addr_o;
    logic [3:0]        dmem_be_o;
    logic [DWIDTH-1:0] dmem_wdata_o;
    logic              dmem_rvalid_i;
    logic [DWIDTH-1:0] dmem_rdata_i;

    logic              wb_valid_o;
    logic              wb_ready_i;
    logic              wb_we_o;
    logic [4:0]        wb_rd_o;
    logic [DWIDTH-1:0] wb_data_o;
    logic              err_o;

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_res_i, ex_rs2_i, ex_opcode_i, ex_funct3_i, ex_rd_i,
        output ex_ready_o,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o,
        input  wb_ready_i
    );

    modport master (
        output ex_valid_i, ex_pc_i, ex_res_i, ex_rs2_i, ex_opcode_i, ex_funct3_i, ex_rd_i,
        input  ex_ready_o,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o,
        output wb_ready_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: one instruction in flight; ALU ops 1 cycle, stores 2+, loads 3+ cycles to writeback.
// Execute is stalled (ex_ready_o=0) until writeback takes the packet; dmem outputs hold until grant.
module mem_access_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    mem_access_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t r_state, w_next;

    logic [1:0]        w_off;
    logic              w_is_load, w_is_store, w_illegal, w_misalign, w_err, w_wb_we;
    logic [3:0]        w_be;
    logic [DWIDTH-1:0] w_wdata, w_wb_data, w_shifted, w_load_data;

    logic [AWIDTH-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DWIDTH-1:0] r_wdata, r_wb_data;
    logic              r_dmem_we, r_wb_we, r_err;
    logic [4:0]        r_rd;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;

    // Decode of the instruction currently offered by execute.
    always_comb begin
        w_off      = bus.ex_res_i[1:0];
        w_is_load  = (bus.ex_opcode_i == OP_LOAD);
        w_is_store = (bus.ex_opcode_i == OP_STORE);
        w_illegal  = 1'b0;
        if (w_is_load)
            w_illegal = (bus.ex_funct3_i == 3'b011) || (bus.ex_funct3_i[2:1] == 2'b11);
        else if (w_is_store)
            w_illegal = (bus.ex_funct3_i >= 3'b011);
        case (bus.ex_funct3_i[1:0])
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = (w_off != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        w_err   = (w_is_load || w_is_store) && (w_illegal || w_misalign);
        w_wb_we = !w_err && (bus.ex_rd_i != 5'd0) &&
                  (w_is_load || bus.ex_opcode_i == OP_OP || bus.ex_opcode_i == OP_OPIMM ||
                   bus.ex_opcode_i == OP_LUI || bus.ex_opcode_i == OP_AUIPC ||
                   bus.ex_opcode_i == OP_JAL || bus.ex_opcode_i == OP_JALR);
        w_be    = 4'b1111;
        w_wdata = bus.ex_rs2_i;
        if (w_is_store) begin
            case (bus.ex_funct3_i[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{bus.ex_rs2_i[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{bus.ex_rs2_i[15:0]}};
                end
                default: ;
            endcase
        end
        if (bus.ex_opcode_i == OP_JAL || bus.ex_opcode_i == OP_JALR)
            w_wb_data = DWIDTH'(bus.ex_pc_i + AWIDTH'(4));
        else
            w_wb_data = bus.ex_res_i;
    end

    // Lane select and extension of the returned read word.
    always_comb begin
        w_shifted = bus.dmem_rdata_i >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{(DWIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{(DWIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load_data = {{(DWIDTH-16){1'b0}}, w_shifted[15:0]};
            default: w_load_data = bus.dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.ex_ready_o = 1'b0;
        bus.dmem_req_o = 1'b0;
        bus.wb_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.ex_ready_o = 1'b1;
                if (bus.ex_valid_i)
                    w_next = ((w_is_load || w_is_store) && !w_err) ? S_REQ : S_RESP;
            end
            S_REQ: begin
                bus.dmem_req_o = 1'b1;
                if (bus.dmem_gnt_i) w_next = r_dmem_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.dmem_rvalid_i) w_next = S_RESP;
            end
            S_RESP: begin
                bus.wb_valid_o = 1'b1;
                if (bus.wb_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
            r_dmem_we <= 1'b0;
            r_wb_we   <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= '0;
            r_off     <= '0;
            r_funct3  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.ex_valid_i) begin
                r_addr    <= {bus.ex_res_i[AWIDTH-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_wb_data <= w_wb_data;
                r_dmem_we <= w_is_store;
                r_wb_we   <= w_wb_we;
                r_err     <= w_err;
                r_rd      <= bus.ex_rd_i;
                r_off     <= w_off;
                r_funct3  <= bus.ex_funct3_i;
            end
            // Read data only counts once the grant has moved us into WAIT.
            if (r_state == S_WAIT && bus.dmem_rvalid_i)
                r_wb_data <= w_load_data;
        end
    end

    assign bus.dmem_we_o    = r_dmem_we;
    assign bus.dmem_addr_o  = r_addr;
    assign bus.dmem_be_o    = r_be;
    assign bus.dmem_wdata_o = r_wdata;
    assign bus.wb_we_o      = r_wb_we;
    assign bus.wb_rd_o      = r_rd;
    assign bus.wb_data_o    = r_wb_data;
    assign bus.err_o        = r_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-in-WAIT sequence and randomized ops
// checked against a behavioural model of the stage's rules.
module tb_mem_access_stage;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct {
        logic [6:0] opc; logic [2:0] f3; logic [31:0] pc, res, rs2; logic [4:0] rd;
        int gw, rw, st; logic [31:0] rdata;
    } op_t;
    typedef struct {
        bit req; int req_cyc; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic mwe;
        int lat; logic we; logic err; logic [31:0] data; bit chk_data;
    } exp_t;
    typedef struct { op_t op; exp_t e; } vec_t;
    typedef struct {
        bit timeout; int req_cyc; bit req_stable; logic [31:0] addr; logic [3:0] be;
        logic [31:0] wdata; logic mwe; int lat; logic we; logic err; logic [4:0] rd;
        logic [31:0] data; bit hold_ok; bit rel_ok;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DWIDTH(32), .AWIDTH(32)) bus ();
    mem_access_stage #(.DWIDTH(32), .AWIDTH(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mko(logic [6:0] opc, logic [2:0] f3, logic [31:0] pc, logic [31:0] res,
                                logic [31:0] rs2, logic [4:0] rd, int gw, int rw, int st,
                                logic [31:0] rdata);
        op_t o;
        o.opc = opc; o.f3 = f3; o.pc = pc; o.res = res; o.rs2 = rs2; o.rd = rd;
        o.gw = gw; o.rw = rw; o.st = st; o.rdata = rdata;
        return o;
    endfunction

    function automatic exp_t mke(bit req, int req_cyc, logic [31:0] addr, logic [3:0] be,
                                 logic [31:0] wdata, logic mwe, int lat, logic we, logic err,
                                 logic [31:0] data, bit chk_data);
        exp_t e;
        e.req = req; e.req_cyc = req_cyc; e.addr = addr; e.be = be; e.wdata = wdata; e.mwe = mwe;
        e.lat = lat; e.we = we; e.err = err; e.data = data; e.chk_data = chk_data;
        return e;
    endfunction

    // Reference model: the stage's rules restated with plain arithmetic.
    function automatic exp_t model(op_t op);
        exp_t e;
        int off, size;
        bit ld, sto, ill, mis;
        logic [31:0] v;
        off  = int'(op.res % 4);
        size = 1 << (op.f3 % 4);
        ld   = (op.opc == OP_LOAD);
        sto  = (op.opc == OP_STORE);
        ill  = ld ? (op.f3 == 3 || op.f3 == 6 || op.f3 == 7) : (sto ? (op.f3 >= 3) : 0);
        mis  = (ld || sto) && !ill && (off % size != 0);
        e = mke(0, 0, 0, 0, 0, sto, 1, 0, ill || mis, op.res, 1);
        e.req = (ld || sto) && !e.err;
        e.req_cyc = op.gw + 1;
        e.addr = op.res - off;
        e.be = 4'hF;
        e.wdata = op.rs2;
        if (sto && op.f3 == 0) begin
            e.be = 4'(1 << off); e.wdata = (op.rs2 % 256) * 32'h0101_0101;
        end else if (sto && op.f3 == 1) begin
            e.be = 4'(3 << off); e.wdata = (op.rs2 % 65536) * 32'h0001_0001;
        end
        if (e.req) e.lat = sto ? op.gw + 2 : op.gw + op.rw + 3;
        e.we = !e.err && op.rd != 0 &&
               (op.opc inside {OP_LOAD, OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
        if (op.opc == OP_JAL || op.opc == OP_JALR) e.data = op.pc + 4;
        if (ld && e.req) begin
            v = op.rdata >> (8 * off);
            case (op.f3)
                3'd0: begin e.data = v % 256;   if (e.data >= 128)   e.data += 32'hFFFF_FF00; end
                3'd1: begin e.data = v % 65536; if (e.data >= 32768) e.data += 32'hFFFF_0000; end
                3'd4: e.data = v % 256;
                3'd5: e.data = v % 65536;
                default: e.data = op.rdata;
            endcase
        end
        e.chk_data = !e.err && !sto;
        return e;
    endfunction

    // Issue one instruction and act as memory/writeback until the packet is consumed.
    task automatic do_op(input op_t op, input bit junk_rv, output obs_t o);
        int cyc, reqn, rwn;
        bit granted;
        o = '{default: 0};
        @(negedge clk);
        bus.ex_valid_i = 1'b1;  bus.ex_opcode_i = op.opc; bus.ex_funct3_i = op.f3;
        bus.ex_pc_i = op.pc;    bus.ex_res_i = op.res;    bus.ex_rs2_i = op.rs2;
        bus.ex_rd_i = op.rd;    bus.wb_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        cyc = 1; reqn = 0; rwn = 0; granted = 0; o.hold_ok = 1; o.req_stable = 1;
        while (!bus.wb_valid_o && cyc < 60) begin
            bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
            if (bus.ex_ready_o) o.hold_ok = 0;
            if (bus.dmem_req_o) begin
                if (reqn == 0) begin
                    o.addr = bus.dmem_addr_o; o.be = bus.dmem_be_o;
                    o.wdata = bus.dmem_wdata_o; o.mwe = bus.dmem_we_o;
                end else if (o.addr !== bus.dmem_addr_o || o.be !== bus.dmem_be_o ||
                             o.wdata !== bus.dmem_wdata_o || o.mwe !== bus.dmem_we_o) begin
                    o.req_stable = 0;
                end
                reqn++;
                if (reqn > op.gw) begin
                    bus.dmem_gnt_i = 1'b1; granted = 1;
                    if (junk_rv) begin bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = ~op.rdata; end
                end
            end else if (granted) begin
                if (rwn >= op.rw) begin bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = op.rdata; end
                rwn++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
        if (!bus.wb_valid_o) begin
            o.timeout = 1;
            return;
        end
        o.lat = cyc; o.req_cyc = reqn;
        o.we = bus.wb_we_o; o.err = bus.err_o; o.rd = bus.wb_rd_o; o.data = bus.wb_data_o;
        if (bus.ex_ready_o) o.hold_ok = 0;
        repeat (op.st) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.wb_valid_o || bus.ex_ready_o || bus.wb_data_o !== o.data ||
                bus.wb_we_o !== o.we || bus.err_o !== o.err || bus.wb_rd_o !== o.rd)
                o.hold_ok = 0;
        end
        bus.wb_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o.rel_ok = bus.ex_ready_o && !bus.wb_valid_o;
        bus.wb_ready_i = 1'b0;
    endtask

    task automatic compare(input string tag, input op_t op, input obs_t o, input exp_t e);
        chk({tag, ".timeout"}, 32'(o.timeout), 32'd0);
        if (o.timeout) return;
        chk({tag, ".lat"}, o.lat, e.lat);
        chk({tag, ".req_cycles"}, o.req_cyc, e.req ? e.req_cyc : 0);
        if (e.req) begin
            chk({tag, ".req_stable"}, 32'(o.req_stable), 32'd1);
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".be"}, 32'(o.be), 32'(e.be));
            chk({tag, ".mem_we"}, 32'(o.mwe), 32'(e.mwe));
            if (e.mwe) chk({tag, ".wdata"}, o.wdata, e.wdata);
        end
        chk({tag, ".wb_we"}, 32'(o.we), 32'(e.we));
        chk({tag, ".err"}, 32'(o.err), 32'(e.err));
        chk({tag, ".rd"}, 32'(o.rd), 32'(op.rd));
        if (e.chk_data) chk({tag, ".data"}, o.data, e.data);
        chk({tag, ".hold"}, 32'(o.hold_ok), 32'd1);
        chk({tag, ".release"}, 32'(o.rel_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[15];
        obs_t o;
        op_t  op;
        logic [6:0] opc_pool[10];

        vecs[0]  = '{mko(OP_OP, 0, 0, 32'h42, 0, 5, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h42, 1)};
        vecs[1]  = '{mko(OP_LOAD, 0, 32'h80, 32'h1003, 0, 3, 0, 0, 0, 32'h80AB_CDEF),
                     mke(1, 1, 32'h1000, 4'hF, 0, 0, 3, 1, 0, 32'hFFFF_FF80, 1)};
        vecs[2]  = '{mko(OP_LOAD, 4, 32'h84, 32'h1003, 0, 3, 0, 0, 0, 32'h80AB_CDEF),
                     mke(1, 1, 32'h1000, 4'hF, 0, 0, 3, 1, 0, 32'h0000_0080, 1)};
        vecs[3]  = '{mko(OP_STORE, 1, 0, 32'h2002, 32'h1234_5678, 7, 3, 0, 0, 0),
                     mke(1, 4, 32'h2000, 4'b1100, 32'h5678_5678, 1, 5, 0, 0, 0, 0)};
        vecs[4]  = '{mko(OP_LOAD, 2, 0, 32'h3001, 0, 4, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        vecs[5]  = '{mko(OP_JAL, 0, 32'h100, 32'h0, 0, 1, 0, 0, 2, 0), mke(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h104, 1)};
        vecs[6]  = '{mko(OP_LOAD, 1, 0, 32'h4002, 0, 8, 0, 1, 0, 32'h8001_7FFF),
                     mke(1, 1, 32'h4000, 4'hF, 0, 0, 4, 1, 0, 32'hFFFF_8001, 1)};
        vecs[7]  = '{mko(OP_LOAD, 5, 0, 32'h4000, 0, 8, 0, 0, 1, 32'h1234_F00D),
                     mke(1, 1, 32'h4000, 4'hF, 0, 0, 3, 1, 0, 32'h0000_F00D, 1)};
        vecs[8]  = '{mko(OP_STORE, 0, 0, 32'h5001, 32'hAABB_CCDD, 0, 0, 0, 0, 0),
                     mke(1, 1, 32'h5000, 4'b0010, 32'hDDDD_DDDD, 1, 2, 0, 0, 0, 0)};
        vecs[9]  = '{mko(OP_STORE, 2, 0, 32'h6000, 32'hCAFE_F00D, 0, 1, 0, 0, 0),
                     mke(1, 2, 32'h6000, 4'hF, 32'hCAFE_F00D, 1, 3, 0, 0, 0, 0)};
        vecs[10] = '{mko(OP_STORE, 3, 0, 32'h7000, 0, 0, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        vecs[11] = '{mko(OP_BRANCH, 0, 0, 32'h1, 0, 9, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1, 1)};
        vecs[12] = '{mko(OP_OPIMM, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h55, 1)};
        vecs[13] = '{mko(OP_LOAD, 1, 0, 32'h4001, 0, 2, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        vecs[14] = '{mko(OP_LOAD, 6, 0, 32'h4000, 0, 2, 0, 0, 0, 0), mke(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};

        bus.ex_valid_i = 0; bus.ex_pc_i = 0; bus.ex_res_i = 0; bus.ex_rs2_i = 0;
        bus.ex_opcode_i = 0; bus.ex_funct3_i = 0; bus.ex_rd_i = 0;
        bus.dmem_gnt_i = 0; bus.dmem_rvalid_i = 0; bus.dmem_rdata_i = 0; bus.wb_ready_i = 0;

        #12;
        chk("reset.ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk("reset.wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk("reset.dmem_req", 32'(bus.dmem_req_o), 32'd0);
        chk("reset.err", 32'(bus.err_o), 32'd0);
        chk("reset.wb_we", 32'(bus.wb_we_o), 32'd0);
        chk("reset.wb_data", bus.wb_data_o, 32'd0);
        chk("reset.dmem_addr", bus.dmem_addr_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, 1'b0, o);
            compare($sformatf("vec%0d", i), vecs[i].op, o, vecs[i].e);
        end

        // Reset while a load waits for its read data; late rvalid must be ignored.
        @(negedge clk);
        bus.ex_valid_i = 1; bus.ex_opcode_i = OP_LOAD; bus.ex_funct3_i = 3'd2;
        bus.ex_res_i = 32'h8000; bus.ex_rd_i = 5'd6;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid_i = 0;
        chk("rstseq.req", 32'(bus.dmem_req_o), 32'd1);
        bus.dmem_gnt_i = 1;
        @(posedge clk);
        @(negedge clk);
        bus.dmem_gnt_i = 0;
        chk("rstseq.wait_ready", 32'(bus.ex_ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq.ready_in_reset", 32'(bus.ex_ready_o), 32'd1);
        chk("rstseq.req_in_reset", 32'(bus.dmem_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.dmem_rvalid_i = 1; bus.dmem_rdata_i = 32'hDEAD_BEEF;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rstseq.late_rvalid%0d.wb_valid", k), 32'(bus.wb_valid_o), 32'd0);
            chk($sformatf("rstseq.late_rvalid%0d.ready", k), 32'(bus.ex_ready_o), 32'd1);
        end
        bus.dmem_rvalid_i = 0;
        op = mko(OP_OP, 0, 0, 32'h77, 0, 12, 0, 0, 0, 0);
        do_op(op, 1'b0, o);
        compare("rstseq.add", op, o, model(op));

        opc_pool = '{OP_LOAD, OP_LOAD, OP_LOAD, OP_STORE, OP_STORE, OP_STORE,
                     OP_OP, OP_LUI, OP_JALR, OP_BRANCH};
        for (int i = 0; i < 150; i++) begin
            op = mko(opc_pool[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            do_op(op, 1'($urandom_range(0, 1)), o);
            compare($sformatf("rnd%0d", i), op, o, model(op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
